// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // One-hot hazard reasons; higher bit means higher priority.
  typedef enum logic [3:0] {
    HZ_NONE    = 4'b0000,
    HZ_LOADUSE = 4'b0001,
    HZ_BRANCH  = 4'b0010,
    HZ_MC      = 4'b0100,
    HZ_MEMWAIT = 4'b1000
  } reason_t;

  function automatic reason_t resolve_reason(input logic memwait, input logic mc,
                                             input logic branch, input logic loaduse);
    if (memwait)      return HZ_MEMWAIT;
    else if (mc)      return HZ_MC;
    else if (branch)  return HZ_BRANCH;
    else if (loaduse) return HZ_LOADUSE;
    else              return HZ_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and the stall/flush controls returned to the pipeline.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       ID_rs0;
  logic [4:0]       ID_rs1;
  logic             ID_use_rs0;
  logic             ID_use_rs1;
  logic [4:0]       EX_rd;
  logic             EX_memread;
  logic             EX_branch_taken;
  logic             EX_mc_start;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_stall;
  logic             IFID_stall;
  logic             IDEX_stall;
  logic             EXMEM_stall;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             EXMEM_flush;
  logic             MEMWB_bubble;
  logic             mc_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ID_rs0, ID_rs1, ID_use_rs0, ID_use_rs1, EX_rd, EX_memread,
           EX_branch_taken, EX_mc_start, dmem_req, dmem_ready,
    input  pc_stall, IFID_stall, IDEX_stall, EXMEM_stall, IFID_flush,
           IDEX_flush, EXMEM_flush, MEMWB_bubble, mc_done, stall_cnt
  );

  modport slave (
    input  ID_rs0, ID_rs1, ID_use_rs0, ID_use_rs1, EX_rd, EX_memread,
           EX_branch_taken, EX_mc_start, dmem_req, dmem_ready,
    output pc_stall, IFID_stall, IDEX_stall, EXMEM_stall, IFID_flush,
           IDEX_flush, EXMEM_flush, MEMWB_bubble, mc_done, stall_cnt
  );

endinterface

// File: rtl/hazard_mc_timer.sv
// Multi-cycle EX occupancy timer: stalls the front end until the op's final EX cycle.
module hazard_mc_timer
  import hazard_pkg::*;
#(
  parameter int MC_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic freeze,
  output logic busy_stall,
  output logic done
);

  localparam int  MCW      = $clog2(MC_CYCLES) + 1;
  localparam bit  MULTI    = (MC_CYCLES > 1);
  localparam int  CNT_LOAD = MULTI ? MC_CYCLES - 2 : 0;

  state_t         state_reg, state_next;
  logic [MCW-1:0] mc_cnt_reg, mc_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      mc_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    if (!freeze) begin
      case (state_reg)
        RUN: begin
          if (start && MULTI) begin
            state_next  = MC_BUSY;
            mc_cnt_next = MCW'(CNT_LOAD);
          end
        end
        MC_BUSY: begin
          if (mc_cnt_reg != '0) mc_cnt_next = mc_cnt_reg - 1'b1;
          else                  state_next  = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // The release cycle ignores start so a still-held start level cannot retrigger.
  always_comb begin
    busy_stall = 1'b0;
    done       = 1'b0;
    case (state_reg)
      RUN: begin
        busy_stall = start && MULTI;
        done       = start && !MULTI;
      end
      MC_BUSY: begin
        busy_stall = (mc_cnt_reg != '0);
        done       = (mc_cnt_reg == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: priority-resolves memory wait, multi-cycle EX, branch
// redirect and load-use into per-register stall/flush controls; counts stall cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  logic [4:0]       src_reg [2];
  logic             src_use [2];
  logic [1:0]       src_hit;
  logic             memwait, loaduse, busy_stall, timer_done;
  reason_t          reason;
  logic [CNT_W-1:0] stall_cnt_reg;

  assign src_reg[0] = hz.ID_rs0;
  assign src_reg[1] = hz.ID_rs1;
  assign src_use[0] = hz.ID_use_rs0;
  assign src_use[1] = hz.ID_use_rs1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src_reg[gi] == hz.EX_rd);
    end
  endgenerate

  assign memwait = hz.dmem_req && !hz.dmem_ready;
  assign loaduse = hz.EX_memread && (hz.EX_rd != REG_X0) && (|src_hit);

  hazard_mc_timer #(.MC_CYCLES(MC_CYCLES)) u_mc_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (hz.EX_mc_start),
    .freeze     (memwait),
    .busy_stall (busy_stall),
    .done       (timer_done)
  );

  always_comb begin
    reason          = resolve_reason(memwait, busy_stall, hz.EX_branch_taken, loaduse);
    hz.pc_stall     = 1'b0;
    hz.IFID_stall   = 1'b0;
    hz.IDEX_stall   = 1'b0;
    hz.EXMEM_stall  = 1'b0;
    hz.IFID_flush   = 1'b0;
    hz.IDEX_flush   = 1'b0;
    hz.EXMEM_flush  = 1'b0;
    hz.MEMWB_bubble = 1'b0;
    // A frozen EX cannot retire the multi-cycle result.
    hz.mc_done      = timer_done && (reason != HZ_MEMWAIT);
    case (reason)
      HZ_MEMWAIT: begin
        hz.pc_stall     = 1'b1;
        hz.IFID_stall   = 1'b1;
        hz.IDEX_stall   = 1'b1;
        hz.EXMEM_stall  = 1'b1;
        hz.MEMWB_bubble = 1'b1;
      end
      HZ_MC: begin
        hz.pc_stall    = 1'b1;
        hz.IFID_stall  = 1'b1;
        hz.IDEX_stall  = 1'b1;
        hz.EXMEM_flush = 1'b1;
      end
      HZ_BRANCH: begin
        hz.IFID_flush = 1'b1;
        hz.IDEX_flush = 1'b1;
      end
      HZ_LOADUSE: begin
        hz.pc_stall   = 1'b1;
        hz.IFID_stall = 1'b1;
        hz.IDEX_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= '0;
    else if (hz.pc_stall && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign hz.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a CNT_W=4, MC_CYCLES=1 instance.
module tb_hazard_ctrl;

  // Control vector: {pc,IFID,IDEX,EXMEM stall, IFID,IDEX,EXMEM flush, MEMWB bubble, mc_done}
  localparam logic [8:0] C_IDLE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110001000;
  localparam logic [8:0] C_MC   = 9'b111000100;
  localparam logic [8:0] C_DONE = 9'b000000001;
  localparam logic [8:0] C_MW   = 9'b111100010;
  localparam logic [8:0] C_BR   = 9'b000011000;
  localparam logic [8:0] C_DBR  = 9'b000011001;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hz1 ();
  hazard_ctrl_if #(.CNT_W(4))  hz2 ();

  hazard_ctrl #(.MC_CYCLES(4), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .hz(hz1));
  hazard_ctrl #(.MC_CYCLES(1), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .hz(hz2));

  wire logic [8:0] ctl1 = {hz1.pc_stall, hz1.IFID_stall, hz1.IDEX_stall, hz1.EXMEM_stall,
                           hz1.IFID_flush, hz1.IDEX_flush, hz1.EXMEM_flush, hz1.MEMWB_bubble,
                           hz1.mc_done};
  wire logic [8:0] ctl2 = {hz2.pc_stall, hz2.IFID_stall, hz2.IDEX_stall, hz2.EXMEM_stall,
                           hz2.IFID_flush, hz2.IDEX_flush, hz2.EXMEM_flush, hz2.MEMWB_bubble,
                           hz2.mc_done};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic idle1();
    hz1.ID_rs0 = 5'd0; hz1.ID_rs1 = 5'd0; hz1.ID_use_rs0 = 1'b0; hz1.ID_use_rs1 = 1'b0;
    hz1.EX_rd = 5'd0; hz1.EX_memread = 1'b0; hz1.EX_branch_taken = 1'b0;
    hz1.EX_mc_start = 1'b0; hz1.dmem_req = 1'b0; hz1.dmem_ready = 1'b0;
  endtask

  task automatic idle2();
    hz2.ID_rs0 = 5'd0; hz2.ID_rs1 = 5'd0; hz2.ID_use_rs0 = 1'b0; hz2.ID_use_rs1 = 1'b0;
    hz2.EX_rd = 5'd0; hz2.EX_memread = 1'b0; hz2.EX_branch_taken = 1'b0;
    hz2.EX_mc_start = 1'b0; hz2.dmem_req = 1'b0; hz2.dmem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle1();
    idle2();
    #1;
    check("rst_ctl", 32'(ctl1), 32'(C_IDLE));
    check("rst_cnt", hz1.stall_cnt, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("idle", 32'(ctl1), 32'(C_IDLE));

    // Load-use on rs1
    @(negedge clk); hz1.EX_memread = 1'b1; hz1.EX_rd = 5'd5; hz1.ID_rs1 = 5'd5; hz1.ID_use_rs1 = 1'b1; #1;
    check("lu_rs1", 32'(ctl1), 32'(C_LU));
    @(negedge clk); hz1.EX_rd = 5'd0; hz1.ID_rs1 = 5'd0; #1;
    check("lu_cnt1", hz1.stall_cnt, 1);
    check("lu_x0", 32'(ctl1), 32'(C_IDLE));
    // Load-use on rs0, then same register but unused
    @(negedge clk); hz1.EX_rd = 5'd7; hz1.ID_rs0 = 5'd7; hz1.ID_use_rs0 = 1'b1; hz1.ID_use_rs1 = 1'b0; #1;
    check("lu_rs0", 32'(ctl1), 32'(C_LU));
    @(negedge clk); hz1.ID_use_rs0 = 1'b0; #1;
    check("lu_nouse", 32'(ctl1), 32'(C_IDLE));
    check("lu_cnt2", hz1.stall_cnt, 2);

    // Multi-cycle op, 4 cycles in EX
    @(negedge clk); idle1(); hz1.EX_mc_start = 1'b1; #1;
    check("mc_t0", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("mc_t1", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("mc_t2", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("mc_t3", 32'(ctl1), 32'(C_DONE));
    @(negedge clk); hz1.EX_mc_start = 1'b0; #1;
    check("mc_after", 32'(ctl1), 32'(C_IDLE));
    check("mc_cnt", hz1.stall_cnt, 5);

    // Completed memory access is not a wait
    @(negedge clk); hz1.dmem_req = 1'b1; hz1.dmem_ready = 1'b1; #1;
    check("mem_ready", 32'(ctl1), 32'(C_IDLE));

    // Multi-cycle op with a 2-cycle memory wait at t+1
    @(negedge clk); idle1(); hz1.EX_mc_start = 1'b1; #1;
    check("mw_t0", 32'(ctl1), 32'(C_MC));
    @(negedge clk); hz1.dmem_req = 1'b1; hz1.dmem_ready = 1'b0; #1;
    check("mw_t1", 32'(ctl1), 32'(C_MW));
    @(negedge clk); #1; check("mw_t2", 32'(ctl1), 32'(C_MW));
    @(negedge clk); hz1.dmem_req = 1'b0; #1;
    check("mw_t3", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("mw_t4", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("mw_t5", 32'(ctl1), 32'(C_DONE));
    @(negedge clk); hz1.EX_mc_start = 1'b0; #1;
    check("mw_cnt", hz1.stall_cnt, 10);

    // Branch overrides load-use
    @(negedge clk); hz1.EX_branch_taken = 1'b1; hz1.EX_memread = 1'b1; hz1.EX_rd = 5'd5;
    hz1.ID_rs1 = 5'd5; hz1.ID_use_rs1 = 1'b1; #1;
    check("br_lu", 32'(ctl1), 32'(C_BR));
    @(negedge clk); idle1(); #1;
    check("br_cnt", hz1.stall_cnt, 10);

    // Branch with multi-cycle: mc wins, branch acted on at release
    @(negedge clk); hz1.EX_mc_start = 1'b1; hz1.EX_branch_taken = 1'b1; #1;
    check("brmc_t0", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("brmc_t1", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("brmc_t2", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("brmc_t3", 32'(ctl1), 32'(C_DBR));
    @(negedge clk); idle1(); #1;
    check("brmc_cnt", hz1.stall_cnt, 13);

    // Reset while MC_BUSY
    @(negedge clk); hz1.EX_mc_start = 1'b1; #1;
    check("rmc_t0", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1;
    check("rmc_t1", 32'(ctl1), 32'(C_MC));
    #1; rst_n = 1'b0; hz1.EX_mc_start = 1'b0; #1;
    check("rmc_ctl", 32'(ctl1), 32'(C_IDLE));
    check("rmc_cnt", hz1.stall_cnt, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rmc_run", 32'(ctl1), 32'(C_IDLE));
    @(negedge clk); hz1.EX_mc_start = 1'b1; #1;
    check("post_t0", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("post_t1", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("post_t2", 32'(ctl1), 32'(C_MC));
    @(negedge clk); #1; check("post_t3", 32'(ctl1), 32'(C_DONE));
    @(negedge clk); idle1(); #1;
    check("post_cnt", hz1.stall_cnt, 3);

    // Single-cycle multi-cycle op: done with no stall
    @(negedge clk); hz2.EX_mc_start = 1'b1; #1;
    check("mc1_a", 32'(ctl2), 32'(C_DONE));
    @(negedge clk); #1;
    check("mc1_b", 32'(ctl2), 32'(C_DONE));
    @(negedge clk); hz2.EX_mc_start = 1'b0; #1;
    check("mc1_cnt", 32'(hz2.stall_cnt), 0);

    // Saturation of a 4-bit counter over 20 load-use stalls
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hz2.EX_memread = 1'b1; hz2.EX_rd = 5'd9; hz2.ID_rs0 = 5'd9; hz2.ID_use_rs0 = 1'b1; #1;
      check("sat_ctl", 32'(ctl2), 32'(C_LU));
      check("sat_cnt", 32'(hz2.stall_cnt), (i < 15) ? i : 15);
    end
    @(negedge clk); idle2(); #1;
    check("sat_final", 32'(hz2.stall_cnt), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
